// File: rtl/agu_pipe_if.sv
// Request/result bundle between issue, the address generation unit and the LSQ.
// out_fault exists only when AGU_BOUND_CHK_EN is defined.
interface agu_pipe_if #(
   parameter int ADDR_W = 16,
   parameter int TAG_W  = 6
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] addr_op1;
   logic [ADDR_W-1:0] addr_op2;
   logic [TAG_W-1:0]  in_tag;
   logic              in_is_st;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] addr_out;
   logic [TAG_W-1:0]  out_tag;
   logic              out_is_st;
   logic              out_wrap;
`ifdef AGU_BOUND_CHK_EN
   logic              out_fault;
`endif

   modport master (
      output flush, in_valid, addr_op1, addr_op2, in_tag, in_is_st, out_ready,
      input  in_ready, out_valid, addr_out, out_tag, out_is_st, out_wrap
`ifdef AGU_BOUND_CHK_EN
      , input out_fault
`endif
   );

   modport slave (
      input  flush, in_valid, addr_op1, addr_op2, in_tag, in_is_st, out_ready,
      output in_ready, out_valid, addr_out, out_tag, out_is_st, out_wrap
`ifdef AGU_BOUND_CHK_EN
      , output out_fault
`endif
   );
endinterface

// File: rtl/agu_pipe.sv
// Pipelined base+offset address generator with elastic valid/ready stages and flush.
// Define AGU_BOUND_CHK_EN to add out_fault (wrap or sum above ADDR_LIMIT).
module agu_pipe #(
   parameter int                ADDR_W     = 16,
   parameter int                TAG_W      = 6,
   parameter int                PIPE_DEPTH = 1,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
   input logic       clk,
   input logic       rst_n,
   agu_pipe_if.slave bus
);

   generate
      if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
         $error("agu_pipe: PIPE_DEPTH must be 1..4");
      end
   endgenerate

   logic [PIPE_DEPTH-1:0] vld;
   logic [PIPE_DEPTH-1:0] rdy;
   logic [ADDR_W-1:0]     addr_q [PIPE_DEPTH];
   logic [TAG_W-1:0]      tag_q  [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] st_q;
   logic [PIPE_DEPTH-1:0] wrap_q;
   logic [ADDR_W:0]       sum;
   logic                  accept;
`ifdef AGU_BOUND_CHK_EN
   logic [PIPE_DEPTH-1:0] fault_q;
   logic                  fault_d;
`endif

   assign sum = {1'b0, bus.addr_op1} + {1'b0, bus.addr_op2};

`ifdef AGU_BOUND_CHK_EN
   assign fault_d = sum[ADDR_W] || (sum[ADDR_W-1:0] > ADDR_LIMIT);
`endif

   // A stage is ready if it or any stage downstream of it has a hole, or the sink takes data.
   always_comb begin : ready_chain
      logic acc;
      acc = bus.out_ready;
      rdy = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         acc    = acc || !vld[k];
         rdy[k] = acc;
      end
   end

   assign bus.in_ready = rdy[0] && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld    <= '0;
         st_q   <= '0;
         wrap_q <= '0;
`ifdef AGU_BOUND_CHK_EN
         fault_q <= '0;
`endif
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            addr_q[k] <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         if (bus.flush)
            vld[0] <= 1'b0;
         else if (rdy[0])
            vld[0] <= bus.in_valid;

         if (accept) begin
            addr_q[0] <= sum[ADDR_W-1:0];
            tag_q[0]  <= bus.in_tag;
            st_q[0]   <= bus.in_is_st;
            wrap_q[0] <= sum[ADDR_W];
`ifdef AGU_BOUND_CHK_EN
            fault_q[0] <= fault_d;
`endif
         end

         for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (bus.flush)
               vld[k] <= 1'b0;
            else if (rdy[k])
               vld[k] <= vld[k-1];

            // Payload moves only on a real transfer so idle stages do not toggle.
            if (!bus.flush && rdy[k] && vld[k-1]) begin
               addr_q[k] <= addr_q[k-1];
               tag_q[k]  <= tag_q[k-1];
               st_q[k]   <= st_q[k-1];
               wrap_q[k] <= wrap_q[k-1];
`ifdef AGU_BOUND_CHK_EN
               fault_q[k] <= fault_q[k-1];
`endif
            end
         end
      end
   end

   assign bus.out_valid = vld[PIPE_DEPTH-1];
   assign bus.addr_out  = addr_q[PIPE_DEPTH-1];
   assign bus.out_tag   = tag_q[PIPE_DEPTH-1];
   assign bus.out_is_st = st_q[PIPE_DEPTH-1];
   assign bus.out_wrap  = wrap_q[PIPE_DEPTH-1];
`ifdef AGU_BOUND_CHK_EN
   assign bus.out_fault = fault_q[PIPE_DEPTH-1];
`endif

endmodule

// File: tb/tb_agu_pipe.sv
// Directed bench for agu_pipe: a depth-2 instance for streaming/backpressure/flush/bounds
// and a depth-4 instance for the full-pipe mid-operation reset.
module tb_agu_pipe;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   agu_pipe_if #(.ADDR_W(16), .TAG_W(6)) bus_a ();
   agu_pipe_if #(.ADDR_W(16), .TAG_W(6)) bus_b ();

   agu_pipe #(.ADDR_W(16), .TAG_W(6), .PIPE_DEPTH(2), .ADDR_LIMIT(16'h7FFF)) u_d2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   agu_pipe #(.ADDR_W(16), .TAG_W(6), .PIPE_DEPTH(4), .ADDR_LIMIT(16'h7FFF)) u_d4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [15:0] op1, input logic [15:0] op2,
                          input logic [5:0] tag, input logic st);
      bus_a.in_valid = v;
      bus_a.addr_op1 = op1;
      bus_a.addr_op2 = op2;
      bus_a.in_tag   = tag;
      bus_a.in_is_st = st;
   endtask

   task automatic drive_b(input logic v, input logic [15:0] op1, input logic [15:0] op2,
                          input logic [5:0] tag, input logic st);
      bus_b.in_valid = v;
      bus_b.addr_op1 = op1;
      bus_b.addr_op2 = op2;
      bus_b.in_tag   = tag;
      bus_b.in_is_st = st;
   endtask

   logic [15:0] s_op1  [4] = '{16'h1000, 16'h2000, 16'h0010, 16'hFFF0};
   logic [15:0] s_op2  [4] = '{16'h0004, 16'h0010, 16'hFFFF, 16'h0020};
   logic [15:0] s_addr [4] = '{16'h1004, 16'h2010, 16'h000F, 16'h0010};
   logic [5:0]  s_tag  [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
   logic        s_st   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic        s_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.flush = 1'b0; bus_b.out_ready = 1'b0;
      drive_a(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
      drive_b(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);

      // reset
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", bus_a.out_valid, 0);
      check("rst_addr_out", bus_a.addr_out, 16'h0000);
      check("rst_in_ready", bus_a.in_ready, 1);
      check("rst_d4_out_valid", bus_b.out_valid, 0);
      check("rst_d4_in_ready", bus_b.in_ready, 1);

      // streaming, depth 2, out_ready high
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive_a(1'b1, s_op1[i], s_op2[i], s_tag[i], s_st[i]);
         else       drive_a(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
         #1;
         if (i < 4) check($sformatf("strm_in_ready%0d", i), bus_a.in_ready, 1);
         tick();
         if (i >= 1 && i <= 4) begin
            check($sformatf("strm_valid%0d", i), bus_a.out_valid, 1);
            check($sformatf("strm_addr%0d", i), bus_a.addr_out, s_addr[i-1]);
            check($sformatf("strm_tag%0d", i), bus_a.out_tag, s_tag[i-1]);
            check($sformatf("strm_st%0d", i), bus_a.out_is_st, s_st[i-1]);
            check($sformatf("strm_wrap%0d", i), bus_a.out_wrap, s_wrap[i-1]);
         end else begin
            check($sformatf("strm_idle%0d", i), bus_a.out_valid, 0);
         end
      end

      // backpressure, depth 2
      bus_a.out_ready = 1'b0;
      drive_a(1'b1, 16'h0100, 16'h0001, 6'd10, 1'b0);
      #1;
      check("bp_rdy_a", bus_a.in_ready, 1);
      tick();
      drive_a(1'b1, 16'h0200, 16'h0002, 6'd11, 1'b1);
      #1;
      check("bp_rdy_b", bus_a.in_ready, 1);
      tick();
      check("bp_valid", bus_a.out_valid, 1);
      check("bp_addr_a", bus_a.addr_out, 16'h0101);
      drive_a(1'b1, 16'h0300, 16'h0003, 6'd12, 1'b0);
      #1;
      check("bp_full_rdy", bus_a.in_ready, 0);
      tick();
      check("bp_hold_addr1", bus_a.addr_out, 16'h0101);
      check("bp_hold_valid1", bus_a.out_valid, 1);
      tick();
      check("bp_hold_addr2", bus_a.addr_out, 16'h0101);
      check("bp_hold_tag2", bus_a.out_tag, 10);
      check("bp_full_rdy2", bus_a.in_ready, 0);
      bus_a.out_ready = 1'b1;
      #1;
      check("bp_release_rdy", bus_a.in_ready, 1);
      tick();
      drive_a(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
      check("bp_drain_b_addr", bus_a.addr_out, 16'h0202);
      check("bp_drain_b_tag", bus_a.out_tag, 11);
      tick();
      check("bp_drain_c_valid", bus_a.out_valid, 1);
      check("bp_drain_c_addr", bus_a.addr_out, 16'h0303);
      check("bp_drain_c_tag", bus_a.out_tag, 12);
      tick();
      check("bp_empty", bus_a.out_valid, 0);

      // flush with two in flight and a third offered
      bus_a.out_ready = 1'b0;
      drive_a(1'b1, 16'h0400, 16'h0004, 6'd20, 1'b0);
      tick();
      drive_a(1'b1, 16'h0500, 16'h0005, 6'd21, 1'b0);
      tick();
      check("fl_pre_valid", bus_a.out_valid, 1);
      drive_a(1'b1, 16'h0600, 16'h0006, 6'd22, 1'b0);
      bus_a.flush = 1'b1;
      #1;
      check("fl_in_ready", bus_a.in_ready, 0);
      tick();
      bus_a.flush = 1'b0;
      bus_a.out_ready = 1'b1;
      drive_a(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
      #1;
      check("fl_out_valid", bus_a.out_valid, 0);
      check("fl_in_ready_after", bus_a.in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("fl_no_result%0d", i), bus_a.out_valid, 0);
      end

`ifdef AGU_BOUND_CHK_EN
      // bounds with ADDR_LIMIT=0x7FFF
      begin
         logic [15:0] b_op1  [3] = '{16'h7FFF, 16'h7FFF, 16'hFFFF};
         logic [15:0] b_op2  [3] = '{16'h0000, 16'h0001, 16'h0002};
         logic [15:0] b_addr [3] = '{16'h7FFF, 16'h8000, 16'h0001};
         logic        b_wrap [3] = '{1'b0, 1'b0, 1'b1};
         logic        b_flt  [3] = '{1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 5; i++) begin
            if (i < 3) drive_a(1'b1, b_op1[i], b_op2[i], 6'd40 + 6'(i), 1'b0);
            else       drive_a(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
            tick();
            if (i >= 1 && i <= 3) begin
               check($sformatf("bnd_addr%0d", i), bus_a.addr_out, b_addr[i-1]);
               check($sformatf("bnd_wrap%0d", i), bus_a.out_wrap, b_wrap[i-1]);
               check($sformatf("bnd_fault%0d", i), bus_a.out_fault, b_flt[i-1]);
            end
         end
      end
`endif

      // depth 4: fill while stalled, then reset together with flush
      bus_b.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive_b(1'b1, 16'hFFFF, 16'h0005, 6'd33, 1'b1);
         else        drive_b(1'b1, 16'h0001, 16'(i), 6'd33 + 6'(i), 1'b0);
         #1;
         check($sformatf("d4_fill_rdy%0d", i), bus_b.in_ready, 1);
         tick();
      end
      drive_b(1'b1, 16'h0009, 16'h0009, 6'd50, 1'b0);
      #1;
      check("d4_full_rdy", bus_b.in_ready, 0);
      check("d4_full_valid", bus_b.out_valid, 1);
      check("d4_full_addr", bus_b.addr_out, 16'h0004);
      check("d4_full_wrap", bus_b.out_wrap, 1);
      check("d4_full_st", bus_b.out_is_st, 1);
      rst_n = 1'b0;
      bus_b.flush = 1'b1;
      tick();
      check("d4_rst_valid", bus_b.out_valid, 0);
      check("d4_rst_addr", bus_b.addr_out, 0);
      check("d4_rst_tag", bus_b.out_tag, 0);
      check("d4_rst_st", bus_b.out_is_st, 0);
      check("d4_rst_wrap", bus_b.out_wrap, 0);
      rst_n = 1'b1;
      bus_b.flush = 1'b0;
      drive_b(1'b0, 16'h0, 16'h0, 6'd0, 1'b0);
      #1;
      check("d4_rst_in_ready", bus_b.in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
Parametrised, pipelined address generation unit for load/store micro-ops. Computes base + offset over a configurable number of register stages with valid/ready backpressure, per-entry tag and load/store flag, and a wrap indicator. Sits between the issue stage and the load/store queue. Replaces the combinational address adder, whose free signal was never honoured.

Parameters:
ADDR_W, 16, width of base, offset and result
TAG_W, 6, width of the ROB/LSQ tag carried with each request
PIPE_DEPTH, 1, number of register stages, legal range 1..4
ADDR_LIMIT, 16'hFFFF, highest legal address; used only when AGU_BOUND_CHK_EN is defined

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
flush  in  1  kill all in-flight requests, e.g. on branch mispredict
in_valid  in  1  request present
in_ready  out  1  AGU can accept this cycle; this is the real "addr_free"
addr_op1  in  ADDR_W  base operand
addr_op2  in  ADDR_W  offset operand, two's complement
in_tag  in  TAG_W  request tag
in_is_st  in  1  1 = store, 0 = load
out_valid  out  1  result present
out_ready  in  1  downstream accepts
addr_out  out  ADDR_W  effective address
out_tag  out  TAG_W  tag of the result
out_is_st  out  1  load/store flag of the result
out_wrap  out  1  carry-out of the unsigned add, i.e. the address wrapped

Behaviour:
- Reset: while rst_n is 0 at a rising edge, clear every stage valid bit.
  - out_valid=0 after reset; addr_out, out_tag, out_is_st and out_wrap also reset to 0.
  - in_ready=1 on the first cycle after reset.
- Add: compute addr_op1 + addr_op2 modulo 2^ADDR_W in stage 1.
  - out_wrap is bit ADDR_W of the (ADDR_W+1)-bit unsigned sum.
  - Negative offsets therefore wrap silently; for example, 0x0010 + 0xFFFF gives addr 0x000F with wrap=1.
- Input transfer: a request is accepted when in_valid && in_ready at a rising edge.
- Output transfer: a result is consumed when out_valid && out_ready at a rising edge.
- Stages form an elastic pipeline. Stage k holds valid_k plus payload {addr, tag, is_st, wrap}.
  - ready_k = !valid_k || ready_(k+1), where ready after the last stage is out_ready.
  - in_ready = ready_1 && !flush.
- Latency: PIPE_DEPTH cycles from accept to out_valid with no stall. Throughput is one request per cycle.
- Stall: while out_ready=0, all held payloads stay stable.
  - out_valid stays asserted; it never drops without a transfer.
  - Bubbles collapse: an empty stage accepts from its upstream neighbour even while the last stage is stalled.
- Full: all PIPE_DEPTH stages valid and out_ready=0 gives in_ready=0.
- Simultaneous output and input on a full pipe: if out_ready=1, every stage advances and a new request is accepted in the same cycle.
- flush=1: at the next edge all valid bits clear, including a request presented in the same cycle.
  - Any output offered during a flush cycle is discarded; the consumer must ignore out_valid when flush=1.
  - Flush takes effect regardless of out_ready.
- Reset asserted mid-operation behaves as flush plus clearing all payload registers; reset has priority over flush.
- Payload registers load only on transfer into their stage, so there is no toggling while idle.
- Order is preserved: results leave in acceptance order.

Optional Feature:
AGU_BOUND_CHK_EN
- Defined:
  - Adds output port out_fault (1 bit, reset 0).
  - out_fault is set for a result if out_wrap=1 or sum > ADDR_LIMIT. It is computed in stage 1 and travels with the payload.
  - The address is still delivered unchanged; the LSQ raises the exception.
- Not defined:
  - The out_fault port is absent.
  - ADDR_LIMIT is ignored.
  - No compare logic is generated.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> out_valid=0, addr_out=0x0000, in_ready=1.
- Streaming (PIPE_DEPTH=2, out_ready held 1): 4 back-to-back requests (0x1000+0x0004, tag 1; 0x2000+0x0010, tag 2; 0x0010+0xFFFF, tag 3; 0xFFF0+0x0020, tag 4) -> out_valid rises 2 cycles after the first accept, one result per cycle in order:
  - 0x1004/tag1/wrap0
  - 0x2010/tag2/wrap0
  - 0x000F/tag3/wrap1
  - 0x0010/tag4/wrap1
- Backpressure (PIPE_DEPTH=2): out_ready=0 with 3 requests offered -> exactly 2 accepted, then in_ready=0, and addr_out stays constant while stalled. Raise out_ready -> 2 results drain in order; the third request is accepted in the same cycle the first leaves.
- Flush: 2 requests in flight, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, the next cycle out_valid=0, and no result for any of the three tags ever appears.
- Bound check (AGU_BOUND_CHK_EN defined, ADDR_LIMIT=0x7FFF): 0x7FFF+0x0000 -> fault=0; 0x7FFF+0x0001 -> addr 0x8000, fault=1; 0xFFFF+0x0002 -> addr 0x0001, wrap=1, fault=1.
- Mid-operation reset (PIPE_DEPTH=4): full and stalled pipe, assert rst_n=0 together with flush=1 -> next cycle out_valid=0, all payload outputs 0, in_ready=1 after release.
